// File: rtl/fbuff_port_arbiter_pkg.sv
// Shared constants for the full_buffer port-A arbiter: default widths, mode
// encodings, FSM state encodings and round-robin requester indices.
package fbuff_port_arbiter_pkg;

  localparam int unsigned AW_DEF = 19;
  localparam int unsigned DW_DEF = 12;

  localparam logic MODE_PASS = 1'b0;
  localparam logic MODE_PROC = 1'b1;

  localparam logic [1:0] ST_PASS  = 2'd0;
  localparam logic [1:0] ST_PROC  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int unsigned ARB_ALU = 0;
  localparam int unsigned ARB_RD  = 1;

endpackage

// File: rtl/fbuff_rr_arb.sv
// Two-input round-robin arbiter; the requester granted last loses the next tie.
module fbuff_rr_arb
  import fbuff_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic       r_prio;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = i_req;
    if (i_req == 2'b11) begin
      w_gnt = r_prio ? 2'b10 : 2'b01;
    end
  end

  // Pointer moves only when somebody is actually granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'(ARB_ALU);
    end else if (|w_gnt) begin
      r_prio <= w_gnt[ARB_ALU];
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/fbuff_port_arbiter.sv
// Port-A owner for full_buffer: camera writes, ALU writes and readback share one
// registered BRAM port; pass/process mode changes commit only at frame boundaries.
module fbuff_port_arbiter
  import fbuff_port_arbiter_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned CW     = 16
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          pass_thru,
  input  logic          frame_start,
  input  logic          cam_wen,
  input  logic [AW-1:0] cam_waddr,
  input  logic [DW-1:0] cam_wdata,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_waddr,
  input  logic [DW-1:0] alu_wdata,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_rdata,
  output logic          rd_rvalid,
  output logic          mem_wea,
  output logic [AW-1:0] mem_addra,
  output logic [DW-1:0] mem_dina,
  input  logic [DW-1:0] mem_douta,
  output logic          mode_proc,
  output logic [CW-1:0] drop_cnt
);

  logic [1:0]    r_state;
  logic          r_target;
  logic          r_mode_proc;
  logic [RD_LAT:0] r_rd_pipe;
  logic          r_mem_wea;
  logic [AW-1:0] r_mem_addra;
  logic [DW-1:0] r_mem_dina;
  logic [CW-1:0] r_drop_cnt;

  logic          w_cam_is_proc;
  logic          w_cam_wr;
  logic          w_cam_drop;
  logic          w_alu_drop;
  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic          w_req_mode;
  logic          w_drain_tgt;
  logic          w_pipe_busy;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {{(CW-1){1'b0}}, b};
    return s[CW] ? '1 : s[CW-1:0];
  endfunction

  // During DRAIN the camera already follows the pending target mode.
  always_comb begin
    w_cam_is_proc = r_target;
    if (r_state == ST_PASS) w_cam_is_proc = MODE_PASS;
    if (r_state == ST_PROC) w_cam_is_proc = MODE_PROC;
  end

  assign w_cam_wr   = cam_wen & (w_cam_is_proc == MODE_PASS);
  assign w_cam_drop = cam_wen & (w_cam_is_proc == MODE_PROC);
  assign w_alu_drop = alu_valid & (r_state == ST_PASS);

  assign w_req[ARB_ALU] = alu_valid & (r_state == ST_PROC);
  assign w_req[ARB_RD]  = rd_valid & (r_state != ST_DRAIN) & ~w_cam_wr;

  fbuff_rr_arb u_rr_arb (
    .clk   (sys_clk),
    .rst   (rst),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign alu_ready = w_gnt[ARB_ALU] | w_alu_drop;
  assign rd_ready  = w_gnt[ARB_RD];

  assign w_req_mode  = pass_thru ? MODE_PASS : MODE_PROC;
  assign w_drain_tgt = frame_start ? w_req_mode : r_target;
  // The last stage is being presented this cycle, so only earlier stages block commit.
  assign w_pipe_busy = |r_rd_pipe[RD_LAT-1:0];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state     <= ST_PASS;
      r_target    <= MODE_PASS;
      r_mode_proc <= MODE_PASS;
    end else begin
      case (r_state)
        ST_DRAIN: begin
          r_target <= w_drain_tgt;
          if (!w_pipe_busy) begin
            r_mode_proc <= w_drain_tgt;
            r_state     <= (w_drain_tgt == MODE_PROC) ? ST_PROC : ST_PASS;
          end
        end
        default: begin
          if (frame_start && (w_req_mode != r_mode_proc)) begin
            r_target <= w_req_mode;
            r_state  <= ST_DRAIN;
          end
        end
      endcase
    end
  end

  // Registered port stage: the accepted op appears on mem_* one cycle later.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_mem_wea   <= 1'b0;
      r_mem_addra <= '0;
      r_mem_dina  <= '0;
      r_rd_pipe   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_mem_wea  <= 1'b0;
      r_rd_pipe  <= {r_rd_pipe[RD_LAT-1:0], w_gnt[ARB_RD]};
      r_drop_cnt <= sat_add(r_drop_cnt, {1'b0, w_cam_drop} + {1'b0, w_alu_drop});
      if (w_cam_wr) begin
        r_mem_wea   <= 1'b1;
        r_mem_addra <= cam_waddr;
        r_mem_dina  <= cam_wdata;
      end else if (w_gnt[ARB_ALU]) begin
        r_mem_wea   <= 1'b1;
        r_mem_addra <= alu_waddr;
        r_mem_dina  <= alu_wdata;
      end else if (w_gnt[ARB_RD]) begin
        r_mem_addra <= rd_addr;
      end
    end
  end

  assign rd_rvalid = r_rd_pipe[RD_LAT];
  assign rd_rdata  = rd_rvalid ? mem_douta : '0;
  assign mem_wea   = r_mem_wea;
  assign mem_addra = r_mem_addra;
  assign mem_dina  = r_mem_dina;
  assign mode_proc = r_mode_proc;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_fbuff_port_arbiter.sv
// Directed bench for fbuff_port_arbiter with a two-cycle-latency BRAM model on port A.
module tb_fbuff_port_arbiter;

  localparam int AW = 19;
  localparam int DW = 12;
  localparam int CW = 16;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          pass_thru = 1'b1;
  logic          frame_start = 1'b0;
  logic          cam_wen = 1'b0;
  logic [AW-1:0] cam_waddr = '0;
  logic [DW-1:0] cam_wdata = '0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [AW-1:0] alu_waddr = '0;
  logic [DW-1:0] alu_wdata = '0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_rdata;
  logic          rd_rvalid;
  logic          mem_wea;
  logic [AW-1:0] mem_addra;
  logic [DW-1:0] mem_dina;
  logic [DW-1:0] mem_douta;
  logic          mode_proc;
  logic [CW-1:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [DW-1:0] pre_d = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] bram_a;

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    bram_a    <= mem_addra;
    mem_douta <= mem[bram_a];
    if (pre_we) mem[pre_a] <= pre_d;
    else if (mem_wea) mem[mem_addra] <= mem_dina;
  end

  fbuff_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2), .CW(CW)) dut (
    .sys_clk(sys_clk), .rst(rst), .pass_thru(pass_thru), .frame_start(frame_start),
    .cam_wen(cam_wen), .cam_waddr(cam_waddr), .cam_wdata(cam_wdata),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_rdata(rd_rdata), .rd_rvalid(rd_rvalid),
    .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_douta(mem_douta),
    .mode_proc(mode_proc), .drop_cnt(drop_cnt)
  );

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic preload();
    for (int k = 0; k < 4; k++) begin
      pre_we = 1'b1; pre_a = AW'(200 + k); pre_d = DW'(12'h5C0 + k);
      cyc();
    end
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #2;
    n_vec++; if (mode_proc !== 1'b0) begin n_err++; $display("FAIL reset_mode got %0h exp 0", mode_proc); end
    n_vec++; if (mem_wea !== 1'b0) begin n_err++; $display("FAIL reset_wea got %0h exp 0", mem_wea); end
    n_vec++; if (mem_addra !== '0) begin n_err++; $display("FAIL reset_addra got %0h exp 0", mem_addra); end
    n_vec++; if (mem_dina !== '0) begin n_err++; $display("FAIL reset_dina got %0h exp 0", mem_dina); end
    n_vec++; if ({alu_ready, rd_ready, rd_rvalid} !== 3'b000) begin n_err++; $display("FAIL reset_hs got %0b exp 000", {alu_ready, rd_ready, rd_rvalid}); end
    n_vec++; if (rd_rdata !== '0) begin n_err++; $display("FAIL reset_rdata got %0h exp 0", rd_rdata); end
    n_vec++; if (drop_cnt !== '0) begin n_err++; $display("FAIL reset_drop got %0h exp 0", drop_cnt); end
    cyc();
  endtask

  task automatic test_pass_cam();
    for (int i = 0; i < 10; i++) begin
      cam_wen = 1'b1; cam_waddr = AW'(i); cam_wdata = DW'(12'hA00 + i);
      cyc();
      cam_wen = 1'b0;
      n_vec++; if ({mem_wea, mem_addra, mem_dina} !== {1'b1, AW'(i), DW'(12'hA00 + i)}) begin
        n_err++; $display("FAIL cam_wr%0d got we=%0h a=%0h d=%0h exp we=1 a=%0h d=%0h", i, mem_wea, mem_addra, mem_dina, i, 12'hA00 + i);
      end
      cyc();
      n_vec++; if ({mem_wea, mem_addra} !== {1'b0, AW'(i)}) begin
        n_err++; $display("FAIL cam_idle%0d got we=%0h a=%0h exp we=0 a=%0h", i, mem_wea, mem_addra, i);
      end
    end
    n_vec++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL cam_drop got %0d exp 0", drop_cnt); end
  endtask

  task automatic test_pass_alu();
    alu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_waddr = AW'(100 + i); alu_wdata = DW'(12'h300 + i);
      #2;
      n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL alu_pass_rdy%0d got %0h exp 1", i, alu_ready); end
      cyc();
      n_vec++; if (mem_wea !== 1'b0) begin n_err++; $display("FAIL alu_pass_we%0d got %0h exp 0", i, mem_wea); end
    end
    alu_valid = 1'b0;
    n_vec++; if (drop_cnt !== 16'd4) begin n_err++; $display("FAIL alu_pass_drop got %0d exp 4", drop_cnt); end
  endtask

  task automatic test_pass_both();
    cam_wen = 1'b1; cam_waddr = AW'(60); cam_wdata = DW'(12'hA60);
    alu_valid = 1'b1; alu_waddr = AW'(61); alu_wdata = DW'(12'h361);
    rd_valid = 1'b1; rd_addr = AW'(203);
    #2;
    n_vec++; if ({alu_ready, rd_ready} !== 2'b10) begin n_err++; $display("FAIL both_rdy got %0b exp 10", {alu_ready, rd_ready}); end
    cyc();
    cam_wen = 1'b0; alu_valid = 1'b0;
    n_vec++; if ({mem_wea, mem_addra, mem_dina} !== {1'b1, AW'(60), DW'(12'hA60)}) begin
      n_err++; $display("FAIL both_wr got we=%0h a=%0h d=%0h exp we=1 a=3c d=a60", mem_wea, mem_addra, mem_dina);
    end
    n_vec++; if (drop_cnt !== 16'd5) begin n_err++; $display("FAIL both_drop got %0d exp 5", drop_cnt); end
    #2;
    n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL pass_rd_rdy got %0h exp 1", rd_ready); end
    cyc();
    rd_valid = 1'b0;
    n_vec++; if ({mem_wea, mem_addra} !== {1'b0, AW'(203)}) begin n_err++; $display("FAIL pass_rd_addr got we=%0h a=%0h exp we=0 a=cb", mem_wea, mem_addra); end
    for (int c = 2; c <= 4; c++) begin
      #2;
      n_vec++; if (rd_rvalid !== (c == 4)) begin n_err++; $display("FAIL pass_rv c%0d got %0h exp %0h", c, rd_rvalid, c == 4); end
      if (c == 4) begin
        n_vec++; if (rd_rdata !== 12'h5C3) begin n_err++; $display("FAIL pass_rdata got %0h exp 5c3", rd_rdata); end
      end
      cyc();
    end
  endtask

  task automatic test_to_proc();
    pass_thru = 1'b0; frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    n_vec++; if (mode_proc !== 1'b0) begin n_err++; $display("FAIL to_proc_drain got %0h exp 0", mode_proc); end
    cyc();
    n_vec++; if (mode_proc !== 1'b1) begin n_err++; $display("FAIL to_proc_commit got %0h exp 1", mode_proc); end
  endtask

  task automatic test_proc_arb();
    int ab = 0;
    int rb = 0;
    logic exp_rv;
    logic [DW-1:0] exp_d;
    for (int c = 0; c < 10; c++) begin
      alu_valid = (c < 6); alu_waddr = AW'(300 + ab); alu_wdata = DW'(12'h3A0 + ab);
      rd_valid = (c < 6); rd_addr = AW'(200 + rb);
      #2;
      if (c < 6) begin
        n_vec++; if ({alu_ready, rd_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL arb_gnt c%0d got %0b exp %0b", c, {alu_ready, rd_ready}, (c % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      exp_rv = (c == 4) || (c == 6) || (c == 8);
      exp_d = (c == 4) ? 12'h5C0 : (c == 6) ? 12'h5C1 : 12'h5C2;
      n_vec++; if (rd_rvalid !== exp_rv) begin n_err++; $display("FAIL arb_rv c%0d got %0h exp %0h", c, rd_rvalid, exp_rv); end
      if (exp_rv) begin
        n_vec++; if (rd_rdata !== exp_d) begin n_err++; $display("FAIL arb_rdata c%0d got %0h exp %0h", c, rd_rdata, exp_d); end
      end
      cyc();
      if (c < 6 && c % 2 == 0) begin
        n_vec++; if ({mem_wea, mem_addra, mem_dina} !== {1'b1, AW'(300 + ab), DW'(12'h3A0 + ab)}) begin
          n_err++; $display("FAIL arb_alu_wr c%0d got we=%0h a=%0h d=%0h", c, mem_wea, mem_addra, mem_dina);
        end
        ab++;
      end else if (c < 6) begin
        n_vec++; if ({mem_wea, mem_addra} !== {1'b0, AW'(200 + rb)}) begin
          n_err++; $display("FAIL arb_rd_port c%0d got we=%0h a=%0h exp we=0 a=%0h", c, mem_wea, mem_addra, 200 + rb);
        end
        rb++;
      end
    end
    alu_valid = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic test_drain();
    rd_valid = 1'b1; rd_addr = AW'(201);
    #2;
    n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL drain_rd_acc got %0h exp 1", rd_ready); end
    cyc();
    rd_valid = 1'b0; pass_thru = 1'b1; frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    alu_valid = 1'b1; rd_valid = 1'b1;
    cam_wen = 1'b1; cam_waddr = AW'(40); cam_wdata = DW'(12'hA44);
    #2;
    n_vec++; if ({alu_ready, rd_ready, rd_rvalid, mode_proc} !== 4'b0001) begin
      n_err++; $display("FAIL drain_c2 got rdy=%0b rv=%0h mode=%0h exp rdy=00 rv=0 mode=1", {alu_ready, rd_ready}, rd_rvalid, mode_proc);
    end
    cyc();
    cam_wen = 1'b0;
    n_vec++; if ({mem_wea, mem_addra, mem_dina} !== {1'b1, AW'(40), DW'(12'hA44)}) begin
      n_err++; $display("FAIL drain_cam got we=%0h a=%0h d=%0h exp we=1 a=28 d=a44", mem_wea, mem_addra, mem_dina);
    end
    #2;
    n_vec++; if ({alu_ready, rd_ready, rd_rvalid, mode_proc} !== 4'b0011) begin
      n_err++; $display("FAIL drain_c3 got rdy=%0b rv=%0h mode=%0h exp rdy=00 rv=1 mode=1", {alu_ready, rd_ready}, rd_rvalid, mode_proc);
    end
    n_vec++; if (rd_rdata !== 12'h5C1) begin n_err++; $display("FAIL drain_rdata got %0h exp 5c1", rd_rdata); end
    cyc();
    alu_valid = 1'b0; rd_valid = 1'b0;
    n_vec++; if (mode_proc !== 1'b0) begin n_err++; $display("FAIL drain_commit got %0h exp 0", mode_proc); end
    cam_wen = 1'b1; cam_waddr = AW'(50); cam_wdata = DW'(12'hA55);
    cyc();
    cam_wen = 1'b0;
    n_vec++; if ({mem_wea, mem_addra, mem_dina} !== {1'b1, AW'(50), DW'(12'hA55)}) begin
      n_err++; $display("FAIL after_drain_cam got we=%0h a=%0h d=%0h exp we=1 a=32 d=a55", mem_wea, mem_addra, mem_dina);
    end
    n_vec++; if (drop_cnt !== 16'd5) begin n_err++; $display("FAIL drain_drop got %0d exp 5", drop_cnt); end
  endtask

  task automatic test_saturate();
    pass_thru = 1'b0; frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    cyc();
    cam_wen = 1'b1; cam_waddr = AW'(77); cam_wdata = DW'(12'hBAD);
    for (int i = 0; i < 65528; i++) cyc();
    n_vec++; if (drop_cnt !== 16'hFFFD) begin n_err++; $display("FAIL sat_fffd got %0h exp fffd", drop_cnt); end
    n_vec++; if (mem_wea !== 1'b0) begin n_err++; $display("FAIL sat_no_port got %0h exp 0", mem_wea); end
    cyc();
    n_vec++; if (drop_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_fffe got %0h exp fffe", drop_cnt); end
    cyc();
    n_vec++; if (drop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_ffff got %0h exp ffff", drop_cnt); end
    cyc(); cyc();
    n_vec++; if (drop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got %0h exp ffff", drop_cnt); end
    cam_wen = 1'b0;
  endtask

  task automatic test_reset_mid();
    rd_valid = 1'b1; rd_addr = AW'(202);
    #2;
    n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL rmid_acc got %0h exp 1", rd_ready); end
    cyc();
    rd_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    #2;
    n_vec++; if ({mode_proc, mem_wea, alu_ready, rd_ready, rd_rvalid} !== 5'b00000) begin
      n_err++; $display("FAIL rmid_ctl got %0b exp 00000", {mode_proc, mem_wea, alu_ready, rd_ready, rd_rvalid});
    end
    n_vec++; if ({mem_addra, mem_dina, drop_cnt, rd_rdata} !== '0) begin
      n_err++; $display("FAIL rmid_data got a=%0h d=%0h cnt=%0h rd=%0h exp all 0", mem_addra, mem_dina, drop_cnt, rd_rdata);
    end
    for (int c = 0; c < 4; c++) begin
      cyc();
      n_vec++; if (rd_rvalid !== 1'b0) begin n_err++; $display("FAIL rmid_rv%0d got %0h exp 0", c, rd_rvalid); end
    end
  endtask

  initial begin
    preload();
    test_reset();
    test_pass_cam();
    test_pass_alu();
    test_pass_both();
    test_to_proc();
    test_proc_arb();
    test_drain();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
